// File: rtl/main_mem_block_ctrl.sv
// ---------------------------------------------------------------------------
// main_mem_block_ctrl
//   Main-memory stage behind a direct-mapped cache. Serves 4-word (128-bit)
//   block fills and write-backs out of a 256 x 32-bit array. Each request
//   waits LATENCY cycles, then moves one word per cycle for four beats,
//   then pulses ready for one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (memory contents survive it)
//   req        request strobe, sampled only while idle
//   readWrite  1 = write block, 0 = read block (latched at accept)
//   addr       byte address; block base word = {addr[9:4], 2'b00}
//   writeData  block to write, word0 = [31:0] ... word3 = [127:96]
//   readData   block read, same packing; valid at and after ready
//   busy       high whenever an operation is in flight
//   ready      one-cycle completion pulse
// ---------------------------------------------------------------------------
module main_mem_block_ctrl #(
  parameter int LATENCY = 4,
  parameter int WORDS   = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         readWrite,
  input  logic [9:0]   addr,
  input  logic [127:0] writeData,
  output logic [127:0] readData,
  output logic         busy,
  output logic         ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef logic [WORDS-1:0][31:0] memArray_t;

  // Power-up image: every word holds its own index.
  function automatic memArray_t initMem();
    memArray_t m;
    for (int i = 0; i < WORDS; i++) m[i] = 32'(i);
    return m;
  endfunction

  // NOTE: the storage array is deliberately kept out of the reset domain;
  // only the control state is reset, so write beats that already landed
  // survive a mid-operation reset.
  memArray_t memory = initMem();

  logic [1:0]       state;
  logic [CNT_W-1:0] waitCnt;
  logic [1:0]       beat;
  logic             latWrite;
  logic [5:0]       latBase;
  logic [127:0]     latData;

  // Byte offset within the block selects nothing; only the block number matters.
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr[3:0];

  assign busy  = (state != IDLE);
  assign ready = (state == DONE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values and the beat/word index stays consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      waitCnt  <= '0;
      beat     <= '0;
      readData <= '0;
      latWrite <= 1'b0;
      latBase  <= '0;
      latData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            latWrite <= readWrite;
            latBase  <= addr[9:4];
            latData  <= writeData;
            waitCnt  <= '0;
            beat     <= '0;
            state    <= (LATENCY > 0) ? WAIT : XFER;
          end
        end
        WAIT: begin
          if (waitCnt == CNT_W'(LATENCY - 1)) begin
            waitCnt <= '0;
            state   <= XFER;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        XFER: begin
          if (!latWrite) readData[beat*32 +: 32] <= memory[{latBase, beat}];
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= DONE;
        end
        default: state <= IDLE;  // DONE: single-cycle ready, then idle
      endcase
    end
  end

  // Write beats; gated by the reset-domain state so a reset stops them at once.
  always_ff @(posedge clk) begin
    if (state == XFER && latWrite) memory[{latBase, beat}] <= latData[beat*32 +: 32];
  end

endmodule

// File: tb/tb_main_mem_block_ctrl.sv
module tb_main_mem_block_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         reqI[2];
  logic         rwI[2];
  logic [9:0]   addrI[2];
  logic [127:0] wdI[2];
  logic [127:0] rdO[2];
  logic         busyO[2];
  logic         readyO[2];

  int lat[2] = '{4, 0};

  always #5 clk = ~clk;

  main_mem_block_ctrl #(.LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(reqI[0]), .readWrite(rwI[0]), .addr(addrI[0]),
    .writeData(wdI[0]), .readData(rdO[0]), .busy(busyO[0]), .ready(readyO[0]));

  main_mem_block_ctrl #(.LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(reqI[1]), .readWrite(rwI[1]), .addr(addrI[1]),
    .writeData(wdI[1]), .readData(rdO[1]), .busy(busyO[1]), .ready(readyO[1]));

  // Reference model: plain word arrays and the last block read, per instance.
  logic [31:0]  mdl[2][256];
  logic [127:0] mrd[2];
  int           opsExpected[2] = '{0, 0};
  int           readyCnt[2]    = '{0, 0};

  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) if (readyO[u] === 1'b1) readyCnt[u]++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelOp(input int u, input bit rw, input logic [9:0] a, input logic [127:0] wd);
    int base = int'(a) / 16 * 4;
    for (int k = 0; k < 4; k++) begin
      if (rw) mdl[u][base+k] = wd[32*k +: 32];
      else    mrd[u][32*k +: 32] = mdl[u][base+k];
    end
  endtask

  // Issue one request, verify latency, readData against the model, and the
  // return to idle. Inputs are scrambled after accept to prove they are latched.
  task automatic runOp(input int u, input bit rw, input logic [9:0] a,
                       input logic [127:0] wd, input string tag, output logic [127:0] rd);
    int edges;
    @(negedge clk);
    rwI[u] = rw; addrI[u] = a; wdI[u] = wd; reqI[u] = 1'b1;
    @(posedge clk); edges = 1; #1;
    check({tag, " busy after accept"}, 128'(busyO[u]), 128'(1));
    @(negedge clk);
    reqI[u] = 1'b0; rwI[u] = ~rw; addrI[u] = 10'($urandom);
    wdI[u] = {$urandom, $urandom, $urandom, $urandom};
    while (readyO[u] !== 1'b1 && edges < 60) begin
      @(posedge clk); edges++; #1;
    end
    modelOp(u, rw, a, wd);
    opsExpected[u]++;
    check({tag, " latency edges"}, 128'(edges), 128'(lat[u] + 5));
    check({tag, " readData"}, rdO[u], mrd[u]);
    rd = rdO[u];
    @(posedge clk); #1;
    check({tag, " idle after done"}, 128'({busyO[u], readyO[u]}), 128'(0));
  endtask

  typedef struct {
    int           unit;
    bit           rw;
    logic [9:0]   addr;
    logic [127:0] wd;
    logic [127:0] expRd;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [127:0] rd;
    int edges;
    int cntSnap;

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 256; i++) mdl[u][i] = 32'(i);
      mrd[u] = '0; reqI[u] = 1'b0; rwI[u] = 1'b0; addrI[u] = '0; wdI[u] = '0;
    end

    // Reset state
    rst_n = 1'b0;
    #2;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset u%0d readData", u), rdO[u], '0);
      check($sformatf("reset u%0d busy/ready", u), 128'({busyO[u], readyO[u]}), 128'(0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table: read fill, write-back, read-back, zero-latency read.
    vecs[0] = '{0, 1'b0, 10'd16, 128'd0, {32'd7, 32'd6, 32'd5, 32'd4}};
    vecs[1] = '{0, 1'b1, 10'd35, {32'd40, 32'd30, 32'd20, 32'd10}, {32'd7, 32'd6, 32'd5, 32'd4}};
    vecs[2] = '{0, 1'b0, 10'd32, 128'd0, {32'd40, 32'd30, 32'd20, 32'd10}};
    vecs[3] = '{1, 1'b0, 10'd0, 128'd0, {32'd3, 32'd2, 32'd1, 32'd0}};
    for (int i = 0; i < 4; i++) begin
      runOp(vecs[i].unit, vecs[i].rw, vecs[i].addr, vecs[i].wd, $sformatf("vec%0d", i), rd);
      check($sformatf("vec%0d table readData", i), rd, vecs[i].expRd);
    end

    // Requests during WAIT and DONE are ignored.
    @(negedge clk);
    rwI[0] = 1'b0; addrI[0] = 10'd16; reqI[0] = 1'b1;
    @(posedge clk); edges = 1;
    @(negedge clk); reqI[0] = 1'b0;
    @(posedge clk); edges++;
    @(negedge clk); reqI[0] = 1'b1; rwI[0] = 1'b1; addrI[0] = 10'd48; wdI[0] = {4{32'hdead_beef}};
    @(posedge clk); edges++;
    @(negedge clk); reqI[0] = 1'b0;
    #1;
    while (readyO[0] !== 1'b1 && edges < 60) begin
      @(posedge clk); edges++; #1;
    end
    modelOp(0, 1'b0, 10'd16, '0);
    opsExpected[0]++;
    check("busy-req latency", 128'(edges), 128'(9));
    check("busy-req readData", rdO[0], {32'd7, 32'd6, 32'd5, 32'd4});
    @(negedge clk); reqI[0] = 1'b1;
    @(posedge clk); #1;
    check("done-req ignored busy", 128'(busyO[0]), 128'(0));
    @(negedge clk); reqI[0] = 1'b0; rwI[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("busy-req single ready", 128'(readyCnt[0]), 128'(opsExpected[0]));
    runOp(0, 1'b0, 10'd48, '0, "busy-req mem12..15", rd);
    check("busy-req mem12..15 literal", rd, {32'd15, 32'd14, 32'd13, 32'd12});

    // Reset after the second write beat.
    @(negedge clk);
    rwI[0] = 1'b1; addrI[0] = 10'd64; wdI[0] = {32'd99, 32'd98, 32'd97, 32'd96}; reqI[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); reqI[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("mid-reset busy/ready", 128'({busyO[0], readyO[0]}), 128'(0));
    check("mid-reset readData", rdO[0], '0);
    mdl[0][16] = 32'd96; mdl[0][17] = 32'd97;
    mrd[0] = '0; mrd[1] = '0;
    cntSnap = readyCnt[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("mid-reset no ready", 128'(readyCnt[0]), 128'(cntSnap));
    runOp(0, 1'b0, 10'd64, '0, "mid-reset readback", rd);
    check("mid-reset readback literal", rd, {32'd19, 32'd18, 32'd97, 32'd96});

    // Random back-to-back traffic against the model.
    for (int i = 0; i < 40; i++) begin
      int u = int'($urandom_range(1, 0));
      bit rw = 1'($urandom);
      logic [9:0] a = 10'($urandom);
      logic [127:0] wd = {$urandom, $urandom, $urandom, $urandom};
      runOp(u, rw, a, wd, $sformatf("rnd%0d u%0d", i, u), rd);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++)
      check($sformatf("ready count u%0d", u), 128'(readyCnt[u]), 128'(opsExpected[u]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_mem_block_ctrl.md
Name: main_mem_block_ctrl

Overview:
Main-memory stage sitting directly downstream of the direct-mapped cache. It serves block fills and write-backs: 4-word (128-bit) blocks over a 10-bit byte address space of 256 32-bit words. It has a configurable access latency followed by a 4-beat word-serial transfer. Handshake is req/busy/ready, so the cache controller stalls on a miss until ready pulses.

Parameters:
LATENCY, 4, wait cycles before the first transfer beat (0 allowed: WAIT is skipped)
WORDS, 256, memory depth in 32-bit words (fixed by the 10-bit address; not to be overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  1  request strobe; sampled only in IDLE
readWrite  input  1  1 = write block, 0 = read block; latched at accept
addr  input  10  byte address; latched at accept; block base word = {addr[9:4],2'b00}, addr[3:0] ignored
writeData  input  128  block to write, word0 = [31:0] ... word3 = [127:96]; latched at accept
readData  output  128  block read, same word packing
busy  output  1  high whenever state != IDLE
ready  output  1  one-cycle completion pulse

Behaviour:
- Storage: memory[0..255], 32 bits each; initialized at time 0 to memory[i] = i; contents are not touched by reset.
- States: IDLE, WAIT, XFER, DONE.
- Reset (rst_n low, async): state = IDLE; wait counter and beat counter = 0; readData = 0; busy = 0; ready = 0.
- IDLE: req=1 at a rising edge accepts the request and latches readWrite, addr and writeData. Next state is WAIT if LATENCY>0, else XFER. req=0 stays in IDLE.
- WAIT: counts LATENCY cycles, then moves to XFER with beat = 0.
- XFER: one word per cycle, beat k = 0..3 targets word base+k.
  - Read: readData[32k+31:32k] <= memory[base+k].
  - Write: memory[base+k] <= latched writeData word k.
  - After beat 3, next state is DONE.
- DONE: ready = 1 for exactly this one cycle, then unconditional return to IDLE. A req in the DONE cycle is ignored.
- Latency: ready is high after exactly LATENCY+5 rising edges, counting the accepting edge as edge 1. Default = 9 edges.
- req while busy (WAIT/XFER/DONE): ignored, never queued; the latched operands are not disturbed.
- Input changes after accept have no effect on the operation in flight.
- readData holding rules:
  - Updated only during read XFER beats.
  - Held stable from DONE until the next read's first beat.
  - Unchanged by write operations.
  - During a read XFER, readData is a partial mix of old and new words; consumers use it only at or after ready.
- Reset mid-operation: returns to IDLE immediately and no ready is issued. Write beats already performed remain in memory; remaining beats are dropped.
- No address out of range: 10-bit addr covers exactly 256 words; base+3 never exceeds 255.

Test Plan:
1. Read fill: req=1, readWrite=0, addr=10'd16 (LATENCY=4) -> busy=1 from the edge after accept; ready pulses once after 9 edges; readData = {32'd7,32'd6,32'd5,32'd4}; busy=0 the following cycle.
2. Write-back then read-back: write addr=10'd35, writeData={32'd40,32'd30,32'd20,32'd10} -> memory[8..11] = 10,20,30,40; readData unchanged by the write. A subsequent read of addr=10'd32 -> readData = {32'd40,32'd30,32'd20,32'd10}.
3. Request while busy: start a read of addr 10'd16, then pulse req with addr=10'd48 during WAIT and again in DONE -> single ready; readData = {7,6,5,4}; memory[12..15] stay 12..15; only one operation completes.
4. Reset mid-write: write addr=10'd64, writeData={32'd99,32'd98,32'd97,32'd96}; drop rst_n just after the second XFER beat -> immediately busy=0, ready=0, readData=0. memory[16]=96 and memory[17]=97, while memory[18]=18 and memory[19]=19; no ready pulse ever issues.
5. LATENCY=0 instance: read addr=10'd0 -> ready after 5 edges; readData = {32'd3,32'd2,32'd1,32'd0}.
6. Back-to-back: issue req in the first IDLE cycle after ready -> accepted; second ready arrives exactly LATENCY+5 edges later; no request lost or duplicated.
